// File: rtl/trng_collector.sv
// trng_collector: consumer end of the ring-oscillator TRNG macro.
// Controls the oscillator reset, samples the asynchronous raw bit through a
// 2-FF synchronizer, removes bias with a von Neumann corrector and packs the
// corrected bits into WORD_W-bit words offered on a valid/ready interface.
// Optional macro TRNG_HEALTH_EN adds a repetition-count health test on the
// raw samples; without it health_fail_o is tied low.
`timescale 1ns/1ps
module trng_collector #(
  parameter int unsigned WORD_W     = 32,
  parameter int unsigned SAMPLE_DIV = 8,
  parameter int unsigned WARMUP_CYC = 256,
  parameter int unsigned REP_LIMIT  = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic              trng_i,
  output logic              osc_rst_o,
  output logic [WORD_W-1:0] data_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              health_fail_o
);

  localparam int unsigned SampW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int unsigned WarmW = $clog2(WARMUP_CYC + 1);
  localparam int unsigned BitW  = $clog2(WORD_W + 1);
  localparam int unsigned RunW  = $clog2(REP_LIMIT + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WARMUP, ST_COLLECT, ST_FULL} state_e;

  state_e            state_q, state_d;
  logic              osc_rst_q, osc_rst_d;
  logic [1:0]        sync_q;
  logic [SampW-1:0]  samp_cnt_q, samp_cnt_d;
  logic [WarmW-1:0]  warm_cnt_q, warm_cnt_d;
  logic [BitW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              phase_q, phase_d;
  logic              first_q, first_d;
  logic              health_q;
  logic              raw_c, strobe_c, emit_c, word_done_c, load_c, fail_evt_c;

  // Two-flop synchronizer for the asynchronous raw bit
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sync_q <= '0;
    else         sync_q <= {sync_q[0], trng_i};
  end

  assign raw_c       = sync_q[1];
  assign strobe_c    = (state_q == ST_COLLECT) && (samp_cnt_q == SampW'(SAMPLE_DIV - 1));
  // Second sample of a pair that differs from the first: emit the first bit
  assign emit_c      = strobe_c && phase_q && (first_q != raw_c);
  assign word_done_c = emit_c && (bit_cnt_q == BitW'(WORD_W - 1));
  assign load_c      = (state_q == ST_FULL) && en_i && !health_q && (!valid_q || ready_i);

  // FSM state and registered oscillator reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      osc_rst_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      osc_rst_q <= osc_rst_d;
    end
  end

  // FSM next state; disable or a health failure returns to IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (en_i) state_d = ST_WARMUP;
      ST_WARMUP:  if (warm_cnt_q == WarmW'(WARMUP_CYC - 1)) state_d = ST_COLLECT;
      ST_COLLECT: if (word_done_c) state_d = ST_FULL;
      ST_FULL:    if (load_c) state_d = ST_COLLECT;
      default:    state_d = ST_IDLE;
    endcase
    if (!en_i || health_q || fail_evt_c) state_d = ST_IDLE;
  end

  // FSM outputs: oscillators held only while idle
  always_comb begin
    osc_rst_d = 1'b0;
    if (state_d == ST_IDLE) osc_rst_d = 1'b1;
  end

  // Datapath next state: counters, corrector, word shifter, output word
  always_comb begin
    samp_cnt_d = '0;
    warm_cnt_d = '0;
    phase_d    = 1'b0;
    first_d    = first_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    data_d     = data_q;
    valid_d    = valid_q;
    if ((state_q == ST_WARMUP) && (warm_cnt_q != WarmW'(WARMUP_CYC))) begin
      warm_cnt_d = warm_cnt_q + 1'b1;
    end
    if (state_q == ST_COLLECT) begin
      samp_cnt_d = strobe_c ? '0 : samp_cnt_q + 1'b1;
      phase_d    = strobe_c ? ~phase_q : phase_q;
      if (strobe_c && !phase_q) first_d = raw_c;
      if (emit_c && (bit_cnt_q != BitW'(WORD_W))) begin
        shift_d   = {shift_q[WORD_W-2:0], first_q};
        bit_cnt_d = bit_cnt_q + 1'b1;
      end
    end
    if (state_q == ST_IDLE) begin
      shift_d   = '0;
      bit_cnt_d = '0;
    end
    if (load_c) begin
      data_d    = shift_q;
      valid_d   = 1'b1;
      shift_d   = '0;
      bit_cnt_d = '0;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  // Datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      samp_cnt_q <= '0;
      warm_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      phase_q    <= 1'b0;
      first_q    <= 1'b0;
    end else begin
      samp_cnt_q <= samp_cnt_d;
      warm_cnt_q <= warm_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      phase_q    <= phase_d;
      first_q    <= first_d;
    end
  end

`ifdef TRNG_HEALTH_EN
  logic [RunW-1:0] run_q, run_d;
  logic            prev_q;
  logic            health_d;

  // Repetition count on raw samples; run restarts whenever COLLECT is left
  always_comb begin
    run_d      = run_q;
    fail_evt_c = 1'b0;
    if (state_q != ST_COLLECT) begin
      run_d = '0;
    end else if (strobe_c) begin
      if ((run_q == '0) || (raw_c != prev_q)) run_d = RunW'(1);
      else if (run_q != RunW'(REP_LIMIT))     run_d = run_q + 1'b1;
      fail_evt_c = (run_d == RunW'(REP_LIMIT));
    end
    health_d = en_i && (health_q || fail_evt_c);
  end

  // Health registers; failure is sticky until disable
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      run_q    <= '0;
      prev_q   <= 1'b0;
      health_q <= 1'b0;
    end else begin
      run_q    <= run_d;
      health_q <= health_d;
      if (strobe_c) prev_q <= raw_c;
    end
  end
`else
  logic unused_c;
  assign fail_evt_c = 1'b0;
  assign health_q   = 1'b0;
  assign unused_c   = ^RunW'(REP_LIMIT);
`endif

  assign osc_rst_o     = osc_rst_q;
  assign data_o        = data_q;
  assign valid_o       = valid_q;
  assign health_fail_o = health_q;

endmodule

// File: tb/tb_trng_collector.sv
// tb_trng_collector: randomized and directed stimulus for trng_collector,
// checked every cycle against a behavioural model built from queues and
// cycle counts.
`timescale 1ns/1ps
module tb_trng_collector;

  localparam int unsigned WORD_W     = 32;
  localparam int unsigned SAMPLE_DIV = 8;
  localparam int unsigned WARMUP_CYC = 256;
  localparam int unsigned REP_LIMIT  = 32;

  localparam int M_IDLE = 0;
  localparam int M_WARM = 1;
  localparam int M_COLL = 2;
  localparam int M_FULL = 3;

  logic              clk_i = 1'b0;
  logic              rst_ni, en_i, trng_i, ready_i;
  logic              osc_rst_o, valid_o, health_fail_o;
  logic [WORD_W-1:0] data_o;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Model state
  int                m_mode;
  int                m_warm_left;
  int unsigned       m_age;
  bit                m_have_first, m_first;
  bit                m_bits[$];
  bit                m_fail;
  int                m_run;
  bit                m_last;
  bit                m_valid;
  logic [WORD_W-1:0] m_data;
  bit                m_h1, m_h2;
  int unsigned       m_strobes, m_words;

  // Raw bit pattern generator
  int                pmode;
  int unsigned       pidx;
  bit                cur_raw;
  int unsigned       last_seen;

  always #5 clk_i = ~clk_i;

  trng_collector #(
    .WORD_W(WORD_W), .SAMPLE_DIV(SAMPLE_DIV), .WARMUP_CYC(WARMUP_CYC), .REP_LIMIT(REP_LIMIT)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i), .trng_i(trng_i),
    .osc_rst_o(osc_rst_o), .data_o(data_o), .valid_o(valid_o),
    .ready_i(ready_i), .health_fail_o(health_fail_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // First corrected bit lands in the MSB of the word
  function automatic logic [WORD_W-1:0] pack_bits();
    logic [WORD_W-1:0] w;
    w = '0;
    for (int i = 0; i < m_bits.size(); i++) w[WORD_W-1-i] = m_bits[i];
    return w;
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_warm_left = 0; m_age = 0; m_have_first = 0; m_first = 0;
    m_bits.delete(); m_fail = 0; m_run = 0; m_last = 0; m_valid = 0; m_data = '0;
    m_h1 = 0; m_h2 = 0; m_strobes = 0; m_words = 0;
  endtask

  task automatic enter_collect();
    m_mode = M_COLL; m_age = 0; m_have_first = 0; m_run = 0;
  endtask

  // One clock of the reference behaviour, using the inputs held across the edge
  task automatic model_step();
    bit raw, acc, loaded, fail_now;
    raw = m_h2;
    acc = m_valid && ready_i;
    loaded = 0;
    fail_now = 0;
    if (!en_i) begin
      m_mode = M_IDLE; m_fail = 0; m_bits.delete();
    end else begin
      case (m_mode)
        M_IDLE: if (!m_fail) begin m_mode = M_WARM; m_warm_left = WARMUP_CYC; end
        M_WARM: begin
          m_warm_left--;
          if (m_warm_left == 0) enter_collect();
        end
        M_COLL: begin
          if ((m_age % SAMPLE_DIV) == SAMPLE_DIV - 1) begin
            m_strobes++;
`ifdef TRNG_HEALTH_EN
            m_run = (m_run != 0 && raw == m_last) ? m_run + 1 : 1;
            if (m_run > REP_LIMIT) m_run = REP_LIMIT;
            m_last = raw;
            if (m_run == REP_LIMIT) fail_now = 1;
`endif
            if (!m_have_first) begin
              m_first = raw; m_have_first = 1;
            end else begin
              m_have_first = 0;
              if (m_first != raw) m_bits.push_back(m_first);
            end
            if (m_bits.size() == WORD_W) m_mode = M_FULL;
          end
          m_age++;
          if (fail_now) begin m_fail = 1; m_mode = M_IDLE; m_bits.delete(); end
        end
        default: begin
          if (!m_valid || ready_i) begin
            m_data = pack_bits(); m_bits.delete(); loaded = 1; m_words++;
            enter_collect();
          end
        end
      endcase
    end
    if (loaded) m_valid = 1;
    else if (acc) m_valid = 0;
    m_h2 = m_h1;
    m_h1 = trng_i;
  endtask

  task automatic next_bit(output bit b);
    case (pmode)
      1: case (pidx % 4) 0, 3: b = 1; default: b = 0; endcase
      2: case (pidx % 6) 2, 3, 4: b = 1; default: b = 0; endcase
      3: b = 1;
      default: b = 1'($urandom_range(0, 1));
    endcase
    pidx++;
  endtask

  task automatic set_pattern(input int p);
    pmode = p; pidx = 0; last_seen = m_strobes;
    next_bit(cur_raw);
    trng_i = cur_raw;
  endtask

  // Advance one clock: model on posedge, compare and drive on negedge
  task automatic tick();
    @(posedge clk_i);
    model_step();
    @(negedge clk_i);
    check("valid", valid_o, m_valid);
    check("data", data_o, m_data);
    check("osc_rst", osc_rst_o, m_mode == M_IDLE);
    check("health", health_fail_o, m_fail);
    if (m_strobes != last_seen) begin
      last_seen = m_strobes;
      next_bit(cur_raw);
    end
    trng_i = cur_raw;
  endtask

  task automatic wait_words(input int unsigned n, input int unsigned limit, input string tag);
    int unsigned target, k;
    target = m_words + n;
    k = 0;
    while (m_words < target && k < limit) begin tick(); k++; end
    check({tag, "_in_time"}, 32'(m_words >= target), 32'd1);
  endtask

  task automatic wait_full(input int unsigned limit);
    int unsigned k;
    k = 0;
    while (m_mode != M_FULL && k < limit) begin tick(); k++; end
    check("full_in_time", 32'(m_mode == M_FULL), 32'd1);
  endtask

  task automatic wait_bits(input int unsigned n, input int unsigned limit);
    int unsigned k;
    k = 0;
    while (!(m_mode == M_COLL && m_bits.size() == n) && k < limit) begin tick(); k++; end
    check("bits_in_time", 32'(m_bits.size()), 32'(n));
  endtask

  initial begin
    logic [WORD_W-1:0] w1, w2;
    rst_ni = 0; en_i = 0; ready_i = 1; trng_i = 0;
    pmode = 0; pidx = 0; cur_raw = 0; last_seen = 0;
    model_reset();
    repeat (3) @(negedge clk_i);
    check("rst_osc", osc_rst_o, 1);
    check("rst_valid", valid_o, 0);
    check("rst_data", data_o, 0);
    check("rst_health", health_fail_o, 0);
    rst_ni = 1;
    tick(); tick();

    // Oscillator release and alternating 10,01 pairs
    set_pattern(1);
    en_i = 1;
    check("osc_pre", osc_rst_o, 1);
    tick();
    check("osc_fall", osc_rst_o, 0);
    wait_words(1, 3000, "word_aa");
    check("word_aa", data_o, 32'hAAAAAAAA);
    check("word_aa_valid", valid_o, 1);

    // 00,11,10 stream: only the 10 pairs emit
    en_i = 0; tick();
    set_pattern(2);
    en_i = 1;
    wait_words(1, 4000, "word_ff");
    check("word_ff", data_o, 32'hFFFFFFFF);

    // Back-pressure across two completed words
    en_i = 0; tick();
    set_pattern(0);
    ready_i = 0;
    en_i = 1;
    wait_words(1, 4000, "stall_w1");
    w1 = m_data;
    wait_full(4000);
    repeat (40) tick();
    check("stall_data", data_o, w1);
    check("stall_valid", valid_o, 1);
    w2 = pack_bits();
    ready_i = 1; tick(); ready_i = 0;
    check("load2_data", data_o, w2);
    check("load2_valid", valid_o, 1);
    tick();
    check("load2_hold", valid_o, 1);
    ready_i = 1;

    // Drop enable mid-word, then re-enable with a known pattern
    en_i = 0; tick();
    set_pattern(0);
    en_i = 1;
    wait_bits(17, 4000);
    en_i = 0;
    tick();
    check("osc_rise", osc_rst_o, 1);
    set_pattern(1);
    en_i = 1;
    wait_words(1, 3000, "reenable");
    check("reenable_word", data_o, 32'hAAAAAAAA);

    // Random enable and ready activity on a random raw stream
    set_pattern(0);
    for (int i = 0; i < 4000; i++) begin
      ready_i = ($urandom_range(0, 3) != 0);
      if (!en_i) en_i = ($urandom_range(0, 7) == 0);
      else if ($urandom_range(0, 599) == 0) en_i = 0;
      tick();
    end

    // Stuck-at-1 raw source
    ready_i = 1;
    en_i = 0; tick();
    set_pattern(3);
    en_i = 1;
    repeat (WARMUP_CYC + (REP_LIMIT + 2) * SAMPLE_DIV) tick();
`ifdef TRNG_HEALTH_EN
    check("health_set", health_fail_o, 1);
    check("health_idle", osc_rst_o, 1);
`else
    check("health_off", health_fail_o, 0);
`endif
    en_i = 0; tick();
    check("health_clr", health_fail_o, 0);
    en_i = 1; tick();
    check("rewarm_osc", osc_rst_o, 0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
